// File: rtl/imem_loader.sv
// Boot-time loader: takes a length-prefixed byte stream, packs little-endian 32-bit words
// into instruction memory, and holds the CPU in reset until the image is fully written.
module imem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   // One bit wider than the 16-bit length so a full-depth image compares exactly
   localparam int unsigned      LEN_W   = 17;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              arm_c;
   logic              accept_c;
   logic              last_word_c;
   logic [15:0]       len_q;
   logic [15:0]       len_full_c;
   logic [1:0]        byte_idx;
   logic [23:0]       word_buf;
   logic [ADDR_W:0]   word_idx;

   assign accept_c     = s_valid && s_ready;
   assign len_full_c   = {s_data, len_q[7:0]};
   assign last_word_c  = (LEN_W'(word_idx) + LEN_W'(1)) == LEN_W'(len_q);
   assign words_loaded = word_idx;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      arm_c     = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_LEN_LO;
               arm_c     = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (accept_c) begin
               state_nxt = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept_c) begin
               if (len_full_c == 16'd0) begin
                  state_nxt = S_DONE;
               end else if (LEN_W'(len_full_c) > MAX_LEN) begin
                  state_nxt = S_ERR;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept_c && (byte_idx == 2'd3) && last_word_c) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_nxt = S_DONE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         cpu_rst <= 1'b1;
      end else begin
         s_ready <= state_nxt inside {S_LEN_LO, S_LEN_HI, S_DATA};
         busy    <= state_nxt inside {S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH};
         done    <= (state_nxt == S_DONE);
         err     <= (state_nxt == S_ERR);
         cpu_rst <= (state_nxt != S_DONE);
      end
   end

   // Length capture, byte packing and memory write port
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         byte_idx  <= '0;
         word_buf  <= '0;
         word_idx  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (arm_c) begin
            byte_idx <= '0;
            word_idx <= '0;
         end
         if (accept_c) begin
            case (state)
               S_LEN_LO: len_q[7:0]  <= s_data;
               S_LEN_HI: len_q[15:8] <= s_data;
               S_DATA: begin
                  if (byte_idx == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= {s_data, word_buf};
                     mem_addr  <= word_idx[ADDR_W-1:0];
                     word_idx  <= word_idx + (ADDR_W+1)'(1);
                     byte_idx  <= 2'd0;
                  end else begin
                     // Shift in from the top so the first byte ends up in bits [7:0]
                     word_buf <= {s_data, word_buf[23:8]};
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
